// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - dual-slot memory stage: slot-0 load/store over req/gnt/rvalid, slot-1 pass-through
// Optional feature macro: LSU_MISALIGN_EXC_EN (trap misaligned half/word instead of issuing them)
module lsu_stage #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] alu0_i,
  input  logic [31:0] alu1_i,
  input  logic [31:0] sdata0_i,
  input  logic [2:0]  funct3_0_i,
  input  logic        ld0_i,
  input  logic        st0_i,
  input  logic        rdw0_i,
  input  logic        rdw1_i,
  input  logic [4:0]  rd0_i,
  input  logic [4:0]  rd1_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        wm0_o,
  output logic        wm1_o,
  output logic [4:0]  am0_o,
  output logic [4:0]  am1_o,
  output logic [31:0] bypass_lsu0_o,
  output logic [31:0] bypass_lsu1_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data0_o,
  output logic [31:0] wb_data1_o,
  output logic [4:0]  wb_rd0_o,
  output logic [4:0]  wb_rd1_o,
  output logic        wb_we0_o,
  output logic        wb_we1_o,
  output logic        bus_err_o,
  output logic        misaligned_o
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stage_valid_q, stage_valid_d;
  logic [31:0]   alu0_q, alu0_d, alu1_q, alu1_d, sdata0_q, sdata0_d, data0_q, data0_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          ld_q, ld_d, st_q, st_d, rdw0_q, rdw0_d, rdw1_q, rdw1_d;
  logic [4:0]    rd0_q, rd0_d, rd1_q, rd1_d;
  logic          kill0_q, kill0_d, bus_err_q, bus_err_d;

  logic        capture, mis_in, mem_cap, cnt_max, tmo, ld_done;
  logic        idle, we0, we1;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt;

`ifdef LSU_MISALIGN_EXC_EN
  logic mis_q, mis_d;
  assign mis_in = (ld0_i | st0_i) &
                  (((funct3_0_i[1:0] == 2'b01) & alu0_i[0]) |
                   ((funct3_0_i[1:0] == 2'b10) & (alu0_i[1:0] != 2'b00)));
`else
  assign mis_in = 1'b0;
`endif

  assign capture = valid_i & ~stall_o & ~flush_i;
  assign mem_cap = capture & (ld0_i | st0_i) & ~mis_in;
  assign cnt_max = (cnt_q == CW'(WAIT_MAX - 1));
  assign tmo     = cnt_max & ~flush_i &
                   (((state_q == S_REQ) & ~dmem_gnt_i) | ((state_q == S_WAIT) & ~dmem_rvalid_i));
  assign ld_done = ~flush_i & dmem_rvalid_i &
                   ((state_q == S_WAIT) | ((state_q == S_REQ) & dmem_gnt_i & ld_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A granted load under flush still owes a response, so it must be drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (mem_cap) state_d = S_REQ;
      S_REQ: begin
        if (flush_i)         state_d = (dmem_gnt_i & ld_q & ~dmem_rvalid_i) ? S_DRAIN : S_IDLE;
        else if (dmem_gnt_i) state_d = (st_q | dmem_rvalid_i) ? S_IDLE : S_WAIT;
        else if (cnt_max)    state_d = S_IDLE;
      end
      S_WAIT: begin
        if (dmem_rvalid_i)   state_d = S_IDLE;
        else if (flush_i)    state_d = S_DRAIN;
        else if (cnt_max)    state_d = S_IDLE;
      end
      S_DRAIN: if (dmem_rvalid_i | cnt_max) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle         = (state_q == S_IDLE);
    stall_o      = ~idle;
    dmem_req_o   = (state_q == S_REQ);
    dmem_we_o    = dmem_req_o & st_q;
    dmem_addr_o  = dmem_req_o ? {alu0_q[31:2], 2'b00} : 32'h0;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'h0;
    if (dmem_req_o) begin
      unique case (funct3_q[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << alu0_q[1:0];
          dmem_wdata_o = {4{sdata0_q[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = alu0_q[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{sdata0_q[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = sdata0_q;
        end
      endcase
    end
    we0           = stage_valid_q & idle & rdw0_q & ~st_q & ~kill0_q & (rd0_q != 5'd0);
    we1           = stage_valid_q & rdw1_q & (rd1_q != 5'd0);
    wb_valid_o    = stage_valid_q & idle;
    wb_we0_o      = we0;
    wb_we1_o      = we1 & idle;
    wm0_o         = we0;
    wm1_o         = we1;
    am0_o         = rd0_q;
    am1_o         = rd1_q;
    bypass_lsu0_o = data0_q;
    bypass_lsu1_o = alu1_q;
    wb_data0_o    = data0_q;
    wb_data1_o    = alu1_q;
    wb_rd0_o      = rd0_q;
    wb_rd1_o      = rd1_q;
    bus_err_o     = bus_err_q;
`ifdef LSU_MISALIGN_EXC_EN
    misaligned_o  = mis_q;
`else
    misaligned_o  = 1'b0;
`endif
  end

  always_comb begin
    unique case (alu0_q[1:0])
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = alu0_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (funct3_q[1:0])
      2'b00:   load_fmt = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_fmt = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    stage_valid_d = stage_valid_q;
    alu0_d        = alu0_q;
    alu1_d        = alu1_q;
    sdata0_d      = sdata0_q;
    funct3_d      = funct3_q;
    ld_d          = ld_q;
    st_d          = st_q;
    rdw0_d        = rdw0_q;
    rdw1_d        = rdw1_q;
    rd0_d         = rd0_q;
    rd1_d         = rd1_q;
    data0_d       = data0_q;
    kill0_d       = kill0_q;
    bus_err_d     = tmo;
    cnt_d         = (!idle && state_d == state_q) ? cnt_q + CW'(1) : '0;
`ifdef LSU_MISALIGN_EXC_EN
    mis_d         = capture & mis_in;
`endif
    if (capture) begin
      stage_valid_d = 1'b1;
      alu0_d        = alu0_i;
      alu1_d        = alu1_i;
      sdata0_d      = sdata0_i;
      funct3_d      = funct3_0_i;
      ld_d          = ld0_i;
      st_d          = st0_i;
      rdw0_d        = rdw0_i;
      rdw1_d        = rdw1_i;
      rd0_d         = rd0_i;
      rd1_d         = rd1_i;
      data0_d       = alu0_i;
      kill0_d       = mis_in;
    end else if (flush_i || idle) begin
      stage_valid_d = 1'b0;
    end
    if (ld_done) data0_d = load_fmt;
    if (tmo)     kill0_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      stage_valid_q <= 1'b0;
      alu0_q        <= 32'h0;
      alu1_q        <= 32'h0;
      sdata0_q      <= 32'h0;
      funct3_q      <= 3'b000;
      ld_q          <= 1'b0;
      st_q          <= 1'b0;
      rdw0_q        <= 1'b0;
      rdw1_q        <= 1'b0;
      rd0_q         <= 5'd0;
      rd1_q         <= 5'd0;
      data0_q       <= 32'h0;
      kill0_q       <= 1'b0;
      bus_err_q     <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      mis_q         <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      stage_valid_q <= stage_valid_d;
      alu0_q        <= alu0_d;
      alu1_q        <= alu1_d;
      sdata0_q      <= sdata0_d;
      funct3_q      <= funct3_d;
      ld_q          <= ld_d;
      st_q          <= st_d;
      rdw0_q        <= rdw0_d;
      rdw1_q        <= rdw1_d;
      rd0_q         <= rd0_d;
      rd1_q         <= rd1_d;
      data0_q       <= data0_d;
      kill0_q       <= kill0_d;
      bus_err_q     <= bus_err_d;
`ifdef LSU_MISALIGN_EXC_EN
      mis_q         <= mis_d;
`endif
    end
  end
endmodule
